// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad hex-entry scanner.
// The key map is indexed {col,row} and holds one hex nibble per key.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN        = 2'd0,
    ST_PRESS_DEB   = 2'd1,
    ST_ACCEPT      = 2'd2,
    ST_RELEASE_DEB = 2'd3
  } state_e;

  localparam logic [3:0] COLS_RESET = 4'b1110;

  // Nibble {col,row}: col0 = 1 4 7 0, col1 = 2 5 8 F, col2 = 3 6 9 E, col3 = A B C D
  localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

  function automatic logic [3:0] key_lookup(input logic [1:0] col, input logic [1:0] row);
    logic [5:0] base;
    base = {col, row, 2'b00};
    return KEY_MAP[base +: 4];
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] cols);
    logic [1:0] idx;
    case (cols)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_hex_entry_if.sv
// Keypad pins plus the entry outputs; master drives rows/clear, slave is the scanner.
interface keypad_hex_entry_if;
  logic [3:0]  Rows;
  logic        Clear;
  logic [3:0]  Cols;
  logic [15:0] Value;
  logic [3:0]  KeyCode;
  logic        KeyStrobe;

  modport master (output Rows, Clear, input Cols, Value, KeyCode, KeyStrobe);
  modport slave  (input Rows, Clear, output Cols, Value, KeyCode, KeyStrobe);
endinterface

// File: rtl/keypad_row_decode.sv
// Maps a synchronized active-low row pattern to a row index.
// Zero or several low rows are treated as no key.
module keypad_row_decode (
  input  logic [3:0] rows_s,
  output logic       valid,
  output logic [1:0] row_idx
);

  always_comb begin
    valid   = 1'b0;
    row_idx = 2'd0;
    case (rows_s)
      4'b1110: begin valid = 1'b1; row_idx = 2'd0; end
      4'b1101: begin valid = 1'b1; row_idx = 2'd1; end
      4'b1011: begin valid = 1'b1; row_idx = 2'd2; end
      4'b0111: begin valid = 1'b1; row_idx = 2'd3; end
      default: ;
    endcase
  end

endmodule

// File: rtl/keypad_hex_entry.sv
// 4x4 keypad scanner with per-key debounce and a four-digit hex shift register.
//
// state       | meaning
// SCAN        | rotate columns each tick, look for a single low row
// PRESS_DEB   | column held, counting matching samples of the latched key
// ACCEPT      | one cycle: strobe out, digit already shifted into Value
// RELEASE_DEB | column held, counting consecutive all-rows-high samples
module keypad_hex_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  keypad_hex_entry_if.slave  kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE_SCANS);

  state_e            state_q, state_d;
  logic [3:0]        sync1_q, sync1_d;
  logic [3:0]        rows_s_q, rows_s_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]        cols_q, cols_d;
  logic [1:0]        key_row_q, key_row_d;
  logic [15:0]       value_q, value_d;
  logic [3:0]        key_code_q, key_code_d;

  logic              tick;
  logic              row_valid;
  logic [1:0]        row_idx;
  logic              accept;
  logic              advance;
  logic [DEB_W-1:0]  deb_inc;
  logic [3:0]        accept_code;

  keypad_row_decode u_row_decode (
    .rows_s  (rows_s_q),
    .valid   (row_valid),
    .row_idx (row_idx)
  );

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    sync1_d     = kp.Rows;
    rows_s_d    = sync1_q;
    div_d       = tick ? '0 : div_q + 1'b1;
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    cols_d      = cols_q;
    key_row_d   = key_row_q;
    key_code_d  = key_code_q;
    value_d     = value_q;
    accept      = 1'b0;
    advance     = 1'b0;
    deb_inc     = deb_cnt_q + 1'b1;
    // The column is still held on the completing tick, so it names the key.
    accept_code = key_lookup(col_index(cols_q), row_idx);

    case (state_q)
      ST_SCAN: begin
        if (tick) begin
          if (row_valid) begin
            key_row_d = row_idx;
            deb_cnt_d = DEB_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_d = ST_ACCEPT;
            end else begin
              state_d = ST_PRESS_DEB;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_PRESS_DEB: begin
        if (tick) begin
          if (row_valid && (row_idx == key_row_q)) begin
            deb_cnt_d = deb_inc;
            if (deb_inc == DEB_TARGET) begin
              accept  = 1'b1;
              state_d = ST_ACCEPT;
            end
          end else begin
            deb_cnt_d = '0;
            advance   = 1'b1;
            state_d   = ST_SCAN;
          end
        end
      end
      ST_ACCEPT: begin
        deb_cnt_d = '0;
        state_d   = ST_RELEASE_DEB;
      end
      ST_RELEASE_DEB: begin
        if (tick) begin
          if (rows_s_q == 4'hF) begin
            deb_cnt_d = deb_inc;
            if (deb_inc == DEB_TARGET) begin
              deb_cnt_d = '0;
              advance   = 1'b1;
              state_d   = ST_SCAN;
            end
          end else begin
            deb_cnt_d = '0;
          end
        end
      end
      default: begin
        deb_cnt_d = '0;
        state_d   = ST_SCAN;
      end
    endcase

    if (advance) cols_d = {cols_q[2:0], cols_q[3]};
    if (accept) key_code_d = accept_code;

    // Clear beats a simultaneous accept; the strobe and code still go out.
    if (kp.Clear)   value_d = 16'h0000;
    else if (accept) value_d = {value_q[11:0], accept_code};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_SCAN;
      sync1_q    <= 4'hF;
      rows_s_q   <= 4'hF;
      div_q      <= '0;
      deb_cnt_q  <= '0;
      cols_q     <= COLS_RESET;
      key_row_q  <= 2'd0;
      value_q    <= 16'h0000;
      key_code_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rows_s_q   <= rows_s_d;
      div_q      <= div_d;
      deb_cnt_q  <= deb_cnt_d;
      cols_q     <= cols_d;
      key_row_q  <= key_row_d;
      value_q    <= value_d;
      key_code_q <= key_code_d;
    end
  end

  assign kp.Cols      = cols_q;
  assign kp.Value     = value_q;
  assign kp.KeyCode   = key_code_q;
  assign kp.KeyStrobe = (state_q == ST_ACCEPT);

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: a physical keypad model drives the rows from the
// driven columns, and a strobe-driven scoreboard predicts Value/KeyCode.
module tb_keypad_hex_entry;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_hex_entry_if kb();

  keypad_hex_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .Clk   (clk),
    .Reset (rst),
    .kp    (kb)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          n_strobes = 0;
  logic [15:0] pressed = '0;
  logic        force_en = 1'b0;
  logic [3:0]  force_val = 4'hF;
  logic [3:0]  rows_phys;
  logic [3:0]  exp_q[$];
  logic [15:0] exp_value = '0;
  logic [3:0]  exp_code = '0;
  logic        rst_s = 1'b1;
  logic        clr_s = 1'b0;
  logic        prev_strobe = 1'b0;

  function automatic logic [3:0] key_at(input int r, input int c);
    logic [15:0] rw;
    case (r)
      0:       rw = 16'h123A;
      1:       rw = 16'h456B;
      2:       rw = 16'h789C;
      default: rw = 16'h0FED;
    endcase
    return rw[15-4*c -: 4];
  endfunction

  function automatic int key_index(input logic [3:0] code);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_at(r, c) == code) return r*4 + c;
    return 0;
  endfunction

  // A pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    rows_phys = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (kb.Cols[c] == 1'b0)) rows_phys[r] = 1'b0;
  end
  assign kb.Rows = force_en ? force_val : rows_phys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    rst_s <= rst;
    clr_s <= kb.Clear;
  end

  always @(negedge clk) begin
    logic [3:0] c;
    if (rst_s) begin
      exp_value = '0;
      exp_code  = '0;
      chk("rst_cols", kb.Cols, 4'b1110);
      chk("rst_strobe", kb.KeyStrobe, 0);
    end else begin
      if (kb.KeyStrobe) begin
        n_strobes++;
        chk("strobe_width", prev_strobe, 0);
        chk("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          c = exp_q.pop_front();
          exp_code = c;
          if (!clr_s) exp_value = {exp_value[11:0], c};
        end
      end
      if (clr_s) exp_value = '0;
    end
    chk("value", kb.Value, exp_value);
    chk("key_code", kb.KeyCode, exp_code);
    chk("cols_onehot", $countones(~kb.Cols), 1);
    prev_strobe = kb.KeyStrobe;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col_start(input logic [3:0] pat);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = kb.Cols;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (kb.Cols == pat && prev != pat) found = 1'b1;
      prev = kb.Cols;
    end
    chk("wait_col_start", found, 1);
  endtask

  task automatic press_release(input logic [3:0] code);
    int idx;
    idx = key_index(code);
    exp_q.push_back(code);
    pressed[idx] = 1'b1;
    wait_clks(40);
    pressed[idx] = 1'b0;
    wait_clks(24);
  endtask

  initial begin
    int s0;
    kb.Clear = 1'b0;
    wait_clks(3);
    chk("reset_cols", kb.Cols, 4'b1110);
    chk("reset_value", kb.Value, 16'h0000);
    chk("reset_code", kb.KeyCode, 4'h0);
    chk("reset_strobe", kb.KeyStrobe, 0);

    // 1: idle rotation, one column step every 4 clocks
    rst = 1'b0;
    wait_clks(3); chk("t1_c0", kb.Cols, 4'b1110);
    wait_clks(1); chk("t1_c1", kb.Cols, 4'b1101);
    wait_clks(4); chk("t1_c2", kb.Cols, 4'b1011);
    wait_clks(4); chk("t1_c3", kb.Cols, 4'b0111);
    wait_clks(4); chk("t1_c0b", kb.Cols, 4'b1110);

    // 2: key 2 (row 0, col 1) held 40 clocks
    s0 = n_strobes;
    exp_q.push_back(4'h2);
    pressed[key_index(4'h2)] = 1'b1;
    wait_clks(11); chk("t2_pre_strobe", kb.KeyStrobe, 0);
    chk("t2_col_held", kb.Cols, 4'b1101);
    wait_clks(1);  chk("t2_strobe", kb.KeyStrobe, 1);
    chk("t2_code", kb.KeyCode, 4'h2);
    chk("t2_value", kb.Value, 16'h0002);
    wait_clks(27); chk("t2_held_cols", kb.Cols, 4'b1101);
    wait_clks(1);  pressed = '0;
    wait_clks(7);  chk("t2_rel_hold", kb.Cols, 4'b1101);
    wait_clks(1);  chk("t2_rel_adv", kb.Cols, 4'b1011);
    chk("t2_strobe_count", n_strobes - s0, 1);

    // 3: digit sequence
    press_release(4'h1);
    press_release(4'h2);
    press_release(4'h3);
    press_release(4'hA);
    chk("t3_value_123a", kb.Value, 16'h123A);
    press_release(4'h5);
    chk("t3_value_23a5", kb.Value, 16'h23A5);

    // 4: single-sample bounce on key C, then two rows low together
    s0 = n_strobes;
    wait_col_start(4'b0111);
    pressed[key_index(4'hC)] = 1'b1;
    wait_clks(4); pressed = '0;
    wait_clks(3); chk("t4_held", kb.Cols, 4'b0111);
    wait_clks(1); chk("t4_back_scan", kb.Cols, 4'b1110);
    force_val = 4'b1010; force_en = 1'b1;
    wait_clks(40); force_en = 1'b0;
    wait_clks(20);
    chk("t4_no_strobe", n_strobes - s0, 0);
    chk("t4_value", kb.Value, 16'h23A5);

    // 5: Clear coincident with accepting key C
    wait_col_start(4'b0111);
    exp_q.push_back(4'hC);
    pressed[key_index(4'hC)] = 1'b1;
    wait_clks(7); kb.Clear = 1'b1;
    wait_clks(1);
    chk("t5_strobe", kb.KeyStrobe, 1);
    chk("t5_code", kb.KeyCode, 4'hC);
    chk("t5_value", kb.Value, 16'h0000);
    wait_clks(1); kb.Clear = 1'b0;
    wait_clks(30); pressed = '0;
    wait_clks(24);

    // 6: reset mid press-debounce, then mid release-debounce, key held throughout
    wait_col_start(4'b1110);
    pressed[key_index(4'h7)] = 1'b1;
    wait_clks(5);
    rst = 1'b1;
    wait_clks(2);
    chk("t6a_cols", kb.Cols, 4'b1110);
    chk("t6a_value", kb.Value, 16'h0000);
    chk("t6a_code", kb.KeyCode, 4'h0);
    chk("t6a_strobe", kb.KeyStrobe, 0);
    exp_q.push_back(4'h7);
    rst = 1'b0;
    wait_clks(7); chk("t6a_pre", kb.KeyStrobe, 0);
    wait_clks(1); chk("t6a_strobe2", kb.KeyStrobe, 1);
    chk("t6a_value2", kb.Value, 16'h0007);
    wait_clks(10);
    rst = 1'b1;
    wait_clks(2);
    chk("t6b_cols", kb.Cols, 4'b1110);
    chk("t6b_value", kb.Value, 16'h0000);
    chk("t6b_code", kb.KeyCode, 4'h0);
    exp_q.push_back(4'h7);
    s0 = n_strobes;
    rst = 1'b0;
    wait_clks(7); chk("t6b_pre", kb.KeyStrobe, 0);
    wait_clks(1); chk("t6b_strobe", kb.KeyStrobe, 1);
    chk("t6b_code2", kb.KeyCode, 4'h7);
    wait_clks(20); pressed = '0;
    wait_clks(24);
    chk("t6b_one_strobe", n_strobes - s0, 1);
    chk("pending_keys", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
